// File: rtl/prng_gen.sv
// prng_gen: Fibonacci LFSR pseudo-random generator with a de Bruijn mode,
//           seed load, wrap detection and a sticky zero-lock flag.
// Latency: a fire in cycle N shows the new state on o in cycle N+1; one step per cycle.
// Backpressure: the state holds while out_ready is low (no step without en & out_valid & out_ready).
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         generator enable; registered into out_valid
//   mode       0 = maximal LFSR (2^WIDTH-1 period), 1 = de Bruijn (2^WIDTH period)
//   load/seed  synchronous seed load; has priority over a step
//   out_ready  consumer accepts o this cycle
//   o          current generator state (registered)
//   out_valid  o is valid for transfer
//   wrap       one-cycle pulse: the last step returned the state to its start value
//   lock_err   sticky: a step was taken from all-zero in mode 0
//
// WIDTH is legal in 4..32; TAPS[WIDTH-1] must be set for the feedback to be
// a proper Fibonacci polynomial.
module prng_gen #(
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0]  SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             out_valid,
  output logic             wrap,
  output logic             lock_err
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  // An all-zero seed would freeze the maximal LFSR, so reset never lands there.
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? ONE : SEED;

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_start;
  logic             r_vld;
  logic             r_wrap;
  logic             r_lock;

  logic             w_fire;
  logic             w_fb_lin;
  logic             w_low_zero;
  logic             w_fb;
  logic             w_lock_hit;
  logic [WIDTH-1:0] w_step_nxt;
  logic [WIDTH-1:0] w_load_val;

  assign w_fire     = en & r_vld & out_ready;

  // Plain Fibonacci feedback: parity of the tapped state bits.
  assign w_fb_lin   = ^(r_state & TAPS);

  // De Bruijn extension: when all bits except the MSB are zero, flipping the
  // feedback splices the all-zero state in between 10..0 and 0..01.
  assign w_low_zero = (r_state[WIDTH-2:0] == '0);
  assign w_fb       = w_fb_lin ^ (mode & w_low_zero);

  // All-zero in mode 0 can only be reached by leaving mode 1 while sitting on
  // zero; the LFSR would stick there, so step to 1 instead and flag it.
  assign w_lock_hit = ~mode & (r_state == '0);
  assign w_step_nxt = w_lock_hit ? ONE : {r_state[WIDTH-2:0], w_fb};

  // Zero seed is only meaningful in de Bruijn mode.
  assign w_load_val = (~mode && (seed == '0)) ? ONE : seed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED_EFF;
      r_start <= SEED_EFF;
      r_vld   <= 1'b0;
      r_wrap  <= 1'b0;
      r_lock  <= 1'b0;
    end else begin
      r_vld  <= en;
      r_wrap <= 1'b0;
      if (load) begin
        // Load wins over a simultaneous fire and re-arms the wrap reference.
        r_state <= w_load_val;
        r_start <= w_load_val;
        r_lock  <= 1'b0;
      end else if (w_fire) begin
        r_state <= w_step_nxt;
        r_wrap  <= (w_step_nxt == r_start);
        if (w_lock_hit) begin
          r_lock <= 1'b1;
        end
      end
    end
  end

  assign o         = r_state;
  assign out_valid = r_vld;
  assign wrap      = r_wrap;
  assign lock_err  = r_lock;

endmodule

// File: tb/tb_prng_gen.sv
module tb_prng_gen;

  localparam logic [3:0] TP = 4'hC;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic       en        = 1'b0;
  logic       mode      = 1'b0;
  logic       load      = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] seed      = 4'h0;
  logic [3:0] o;
  logic       out_valid;
  logic       wrap;
  logic       lock_err;

  int checks = 0;
  int errors = 0;

  prng_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .load      (load),
    .seed      (seed),
    .out_ready (out_ready),
    .o         (o),
    .out_valid (out_valid),
    .wrap      (wrap),
    .lock_err  (lock_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] m_o     = 4'h1;
  logic [3:0] m_start = 4'h1;
  logic       m_vld   = 1'b0;
  logic       m_wrap  = 1'b0;
  logic       m_lock  = 1'b0;
  logic       m_fire;
  logic [3:0] m_n;

  // Next value: shift left by one, new LSB = parity of the tapped bits,
  // with the de Bruijn correction and the mode-0 zero recovery.
  function automatic logic [3:0] model_next(input logic [3:0] s, input logic md);
    int par;
    if (!md && s == 4'h0) return 4'h1;
    par = $countones(s & TP) % 2;
    if (md && (int'(s) % 8) == 0) par = par ^ 1;
    return 4'((int'(s) * 2 + par) % 16);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_o = 4'h1; m_start = 4'h1; m_vld = 1'b0; m_wrap = 1'b0; m_lock = 1'b0;
    end else begin
      m_fire = en && m_vld && out_ready;
      m_wrap = 1'b0;
      if (load) begin
        m_o     = (!mode && seed == 4'h0) ? 4'h1 : seed;
        m_start = m_o;
        m_lock  = 1'b0;
      end else if (m_fire) begin
        m_n = model_next(m_o, mode);
        if (!mode && m_o == 4'h0) m_lock = 1'b1;
        m_wrap = (m_n == m_start);
        m_o    = m_n;
      end
      m_vld = en;
    end
  end

  always @(negedge clk) begin
    chk("model_o", o, m_o);
    chk("model_valid", out_valid, m_vld);
    chk("model_wrap", wrap, m_wrap);
    chk("model_lock", lock_err, m_lock);
  end

  // ---------------- directed stimulus ----------------
  logic [3:0] seq0 [15] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                            4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
  logic [3:0] seq1 [16] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                            4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int zeros;
    int n;

    // Reset values appear before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_o", o, 4'h1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_lock", lock_err, 1'b0);
    en = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_hold_o", o, 4'h1);
    chk("rst_hold_valid", out_valid, 1'b0);

    // Release: first edge only raises out_valid, stepping starts on the second.
    rst_n = 1'b1;
    tick();
    chk("rel_o", o, 4'h1);
    chk("rel_valid", out_valid, 1'b1);

    // Mode 0, period 15.
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("seq0_o", o, seq0[i]);
      chk("seq0_wrap", wrap, (i == 14));
    end

    // Mode 1, period 16 with exactly one zero.
    mode = 1'b1;
    zeros = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("seq1_o", o, seq1[i]);
      chk("seq1_wrap", wrap, (i == 15));
      if (o == 4'h0) zeros++;
    end
    chk("seq1_zeros", zeros, 1);

    // Backpressure from o = 4.
    mode = 1'b0;
    tick(); tick();
    chk("bp_start", o, 4'h4);
    tick();
    chk("bp_a", o, 4'h9);
    out_ready = 1'b0;
    tick();
    chk("bp_b", o, 4'h9);
    tick();
    chk("bp_c", o, 4'h9);
    out_ready = 1'b1;
    tick();
    chk("bp_d", o, 4'h3);

    // Zero seed loads.
    load = 1'b1; seed = 4'h0; mode = 1'b0;
    tick();
    chk("ld0_m0", o, 4'h1);
    chk("ld0_m0_wrap", wrap, 1'b0);
    mode = 1'b1;
    tick();
    chk("ld0_m1", o, 4'h0);
    load = 1'b0;
    tick();
    chk("ld0_m1_next", o, 4'h1);

    // Run mode 1 to zero, then step in mode 0.
    n = 0;
    while (o != 4'h0 && n < 20) begin
      tick();
      n++;
    end
    chk("reach_zero", o, 4'h0);
    mode = 1'b0;
    tick();
    chk("lock_o", o, 4'h1);
    chk("lock_set", lock_err, 1'b1);
    tick(); tick();
    chk("lock_sticky", lock_err, 1'b1);
    chk("lock_run_o", o, 4'h4);
    load = 1'b1; seed = 4'h5;
    tick();
    load = 1'b0;
    chk("ld5_o", o, 4'h5);
    chk("ld5_lock", lock_err, 1'b0);
    chk("ld5_wrap", wrap, 1'b0);
    n = 0;
    while (wrap !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ld5_period", n, 15);
    chk("ld5_wrap_o", o, 4'h5);

    // Reset mid-run with a simultaneous load.
    tick();
    chk("pre_rst_o", o, 4'hB);
    load = 1'b1; seed = 4'h9; rst_n = 1'b0;
    #1;
    chk("mid_rst_o", o, 4'h1);
    chk("mid_rst_valid", out_valid, 1'b0);
    tick();
    chk("mid_rst_hold", o, 4'h1);
    load = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rel2_o", o, 4'h1);
    chk("rel2_valid", out_valid, 1'b1);
    tick();
    chk("rel2_step", o, 4'h2);

    // Enable drop: out_valid follows en one cycle later, no step meanwhile.
    en = 1'b0;
    tick();
    chk("en0_valid", out_valid, 1'b0);
    chk("en0_o", o, 4'h2);
    en = 1'b1;
    tick();
    chk("en1_valid", out_valid, 1'b1);
    chk("en1_o", o, 4'h2);
    tick();
    chk("en1_step", o, 4'h4);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
